// File: rtl/phase_acc_pkg.sv
// Shared constants and state encoding for the phase accumulator.
package phase_acc_pkg;

   localparam int ASZ_DEF = 24;   // default accumulator / frequency-word width
   localparam int PSZ_DEF = 12;   // default phase output width

   // Frequency-word load FSM: IDLE = no word waiting, PEND = word waiting for ena
   typedef enum logic {
      LD_IDLE = 1'b0,
      LD_PEND = 1'b1
   } ld_state_e;

endpackage

// File: rtl/phase_acc_sync_det.sv
// Hard-sync rising-edge detector with a sticky pending flag.
// The flag is raised by a 0->1 transition on sync and is held until the
// accumulator consumes it on an ena cycle. Only instantiated when
// PHASE_ACC_HARD_SYNC_EN is defined.
module phase_acc_sync_det (
   input  logic clk,
   input  logic reset,
   input  logic sync,
   input  logic consume,
   output logic sync_pend
);

   logic sync_q;
   logic pend_q;
   logic pend_d;
   logic rise;

   assign rise = sync & ~sync_q;

   // A fresh edge wins over a simultaneous consume so no edge is ever lost.
   always_comb begin
      pend_d = pend_q;
      if (consume) pend_d = 1'b0;
      if (rise)    pend_d = 1'b1;
   end

   // Previous-sample register and pending flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         sync_q <= sync;
         pend_q <= pend_d;
      end
   end

   assign sync_pend = pend_q;

endmodule

// File: rtl/phase_acc.sv
// Phase accumulator (NCO core) with double-buffered frequency word.
// A loaded word waits in a pending register and becomes active on the next
// ena cycle, whose increment already uses it; freq_ack pulses the cycle after.
// Optional hard sync: define PHASE_ACC_HARD_SYNC_EN to enable the sync input.
module phase_acc
   import phase_acc_pkg::*;
#(
   parameter int asz = ASZ_DEF,
   parameter int psz = PSZ_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ena,
   input  logic [asz-1:0] freq,
   input  logic           freq_ld,
   output logic           freq_ack,
   input  logic           sync,
   output logic [psz-1:0] phs_out,
   output logic           wrap
);

   ld_state_e      state_q, state_d;
   logic [asz-1:0] acc_q, acc_d;
   logic [asz-1:0] act_q, act_d;
   logic [asz-1:0] pend_q, pend_d;
   logic           ack_q, ack_d;
   logic           wrap_q, wrap_d;
   logic [asz-1:0] inc;
   logic [asz:0]   sum;
   logic           sync_hit;

`ifdef PHASE_ACC_HARD_SYNC_EN
   logic sync_pend;

   phase_acc_sync_det u_sync_det (
      .clk       (clk),
      .reset     (reset),
      .sync      (sync),
      .consume   (ena),
      .sync_pend (sync_pend)
   );

   assign sync_hit = sync_pend & ena;
`else
   // Sync is a no-op in this build; the port stays for pin compatibility.
   logic unused_sync;
   assign unused_sync = sync;
   assign sync_hit    = 1'b0;
`endif

   // Load FSM, accumulator update and wrap/ack pulse generation.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      act_d   = act_q;
      acc_d   = acc_q;
      ack_d   = 1'b0;
      wrap_d  = 1'b0;
      inc     = act_q;

      case (state_q)
         LD_IDLE: begin
            if (freq_ld) begin
               pend_d  = freq;
               state_d = LD_PEND;
            end
         end
         LD_PEND: begin
            if (freq_ld) pend_d = freq;
            if (ena) begin
               // Transfer: this cycle's add already uses the new word.
               act_d = pend_q;
               inc   = pend_q;
               ack_d = 1'b1;
               if (!freq_ld) state_d = LD_IDLE;
            end
         end
         default: state_d = LD_IDLE;
      endcase

      sum = {1'b0, acc_q} + {1'b0, inc};

      if (ena) begin
         acc_d  = sum[asz-1:0];
         wrap_d = sum[asz];
         // Sync discards the add; a coincident carry still gives one pulse.
         if (sync_hit) begin
            acc_d  = '0;
            wrap_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LD_IDLE;
         acc_q   <= '0;
         act_q   <= '0;
         pend_q  <= '0;
         ack_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         wrap_q  <= wrap_d;
      end
   end

   assign phs_out  = acc_q[asz-1 -: psz];
   assign freq_ack = ack_q;
   assign wrap     = wrap_q;

endmodule

// File: doc/phase_acc.md
PHASE_ACC -- requirements
Module: phase_acc

Interface
REQ-001 SHALL have parameter asz, default 24, accumulator and frequency-word bitwidth.
REQ-002 SHALL have parameter psz, default 12, phase output bitwidth; psz <= asz.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ena  input  1  sample-rate enable; accumulator advances only on cycles with ena=1.
REQ-006 SHALL have port freq  input  asz  unsigned frequency (phase increment) word.
REQ-007 SHALL have port freq_ld  input  1  load strobe; freq is captured on every cycle it is high.
REQ-008 SHALL have port freq_ack  output  1  one-cycle pulse when a captured word becomes active.
REQ-009 SHALL have port sync  input  1  hard-sync request, rising-edge sensitive.
REQ-010 SHALL have port phs_out  output  psz  unsigned phase, acc[asz-1:asz-psz], feeding triangle/saw/square shapers.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on phase wrap or sync reset.

Function
REQ-012 SHALL hold acc, active freq word and pending word in registers; phs_out SHALL be taken directly from acc, so it changes the cycle after the ena cycle that updates acc.
REQ-013 SHALL implement a 2-state load FSM: IDLE, PEND.
REQ-014 In IDLE, freq_ld=1 SHALL capture freq into the pending word and go to PEND.
REQ-015 In PEND, freq_ld=1 SHALL overwrite the pending word (latest wins); no extra ack.
REQ-016 In PEND on an ena=1 cycle, the pending word SHALL become active and that cycle's increment SHALL already use it; freq_ack SHALL pulse 1 on the next cycle; FSM SHALL return to IDLE, unless freq_ld=1 on the same cycle, in which case the new word is captured and FSM stays in PEND.
REQ-017 On ena=1, acc SHALL become (acc + active freq) mod 2^asz; wrap SHALL be 1 on the next cycle if the add carried out of bit asz-1.
REQ-018 On ena=0, acc, phs_out and active freq SHALL hold; wrap SHALL be 0.
REQ-019 Active freq = 0 SHALL freeze phase with no wrap pulses.

Reset
REQ-020 reset SHALL asynchronously clear acc, active freq, pending word, FSM (IDLE), sync edge register, sync pending flag, freq_ack, wrap; phs_out SHALL read 0.
REQ-021 reset during PEND SHALL discard the pending word; no freq_ack SHALL follow.

Configuration
REQ-022 Macro PHASE_ACC_HARD_SYNC_EN SHALL compile in hard sync.
REQ-023 With the macro: a sync rising edge (sync=1, previous sample 0) SHALL set a sync pending flag; the next ena=1 cycle SHALL load acc with 0 (discarding the add), clear the flag and pulse wrap on the following cycle; a frequency transfer on that same cycle still occurs; natural carry plus sync SHALL give one wrap pulse.
REQ-024 Without the macro: sync SHALL be ignored, the edge register and flag SHALL not exist, port sync SHALL remain present.

Structure
REQ-025 Package phase_acc_pkg SHALL hold default asz/psz constants and FSM state encoding (IDLE=0, PEND=1).
REQ-026 Sync edge detect plus pending flag SHALL be sub-module phase_acc_sync_det, instantiated only under PHASE_ACC_HARD_SYNC_EN.

Verification (asz=24, psz=12)
REQ-027 Reset, freq=0x001000 strobed, ena continuously 1 -> freq_ack one pulse; phs_out steps 0x001, 0x002, ... one per cycle; wrap after 4096 steps as phs_out returns to 0x000.
REQ-028 freq=0x800000, ena every cycle -> phs_out alternates 0x800/0x000; wrap=1 each cycle after phs_out returns to 0x000.
REQ-029 Build with macro, acc=0x456000, sync 0->1 with ena low, then ena=1 -> phs_out=0x000, single wrap pulse; holding sync high gives no further resets.
REQ-030 freq_ld with 0x002000 then 0x004000 before any ena -> one freq_ack, step size 0x004 per ena.
REQ-031 freq_ld then reset before ena -> no freq_ack, phs_out stays 0x000 with ena=1.
REQ-032 ena=0 for 100 cycles mid-run -> phs_out constant, wrap=0, freq_ack=0.
